serial_subtractor_ctrl: RTL and testbench
=========================================

# serial_subtractor_ctrl

Bit-serial subtractor with its own control FSM, computing `out_diff = data_a - data_b` modulo 2^WIDTH. It is the inverse-operation counterpart of the team's serial adder datapath. On a start pulse, both operands are loaded in parallel and shifted LSB-first through a one-bit full subtractor with a registered borrow. The difference bits are collected into a result register, and completion is signalled with a one-cycle `done` pulse. It sits beside the serial adder in the same shift-register datapath family and reuses the same parallel-in/serial-process/parallel-out structure.

## Interface
- `WIDTH`, default 4: operand and result width in bits (≥2).
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a subtraction; sampled only in IDLE.
- `data_a`  in  WIDTH: minuend, captured on an accepted `start`.
- `data_b`  in  WIDTH: subtrahend, captured on an accepted `start`.
- `busy`  out  1: high while in the SHIFT state.
- `done`  out  1: one-cycle pulse when `out_diff` has just been updated.
- `out_diff`  out  WIDTH: last completed difference, held stable between completions.
- `borrow_out`  out  1: final borrow of the last completed operation. Present only with `SERIAL_SUB_BORROW_OUT_EN`.

## Operation
- Reset values:
  - state = IDLE
  - `busy` = 0, `done` = 0, `out_diff` = 0, `borrow_out` = 0
  - internal shift registers, borrow flip-flop and bit counter all 0
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - If `start` = 1: load `data_a`/`data_b` into shift registers A and B, clear borrow, clear counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: each cycle, with a0 = A[0], b0 = B[0], br = borrow:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift A and B right by one; the vacated MSB is filled with 0.
  - Shift d into the MSB of the internal difference register (right-shift), so after WIDTH shifts bit i sits at position i.
  - Increment the counter. On the cycle the counter reaches WIDTH-1, the FSM goes to DONE.
- DONE:
  - Copy the internal difference register to `out_diff`, copy the final borrow to `borrow_out`, pulse `done`.
  - Return unconditionally to IDLE.
- Arithmetic is unsigned, modulo 2^WIDTH. The final borrow is 1 iff `data_a` < `data_b`.
- A `start` asserted in SHIFT or DONE is ignored: no queuing, operands are not re-sampled.
- Operand inputs may change freely after capture; the computation uses only the captured copies.

## Timing
- Cycle numbering: `start` is sampled high in IDLE at edge k.
- Edges k+1 … k+WIDTH: `busy` = 1.
- Edge k+WIDTH+1: `done` = 1 for exactly one cycle, `busy` = 0. `out_diff` (and `borrow_out`) take their new values on the same edge.
- Latency from `start` to `done`: WIDTH+1 cycles.
- Minimum spacing between accepted starts: WIDTH+2 cycles. `start` held high continuously restarts on the first IDLE cycle after DONE.
- `out_diff` never changes except on the edge where `done` rises, or on reset.
- Reset asserted mid-operation (SHIFT or DONE):
  - On the next edge, everything returns to its reset value, including `out_diff` = 0.
  - The partial result is discarded and no `done` is emitted.
- If `reset` and `start` are both high, reset wins.

## Configuration
- `SERIAL_SUB_BORROW_OUT_EN` defined: the `borrow_out` port exists. It is registered, updated together with `out_diff` on the `done` edge, and reset to 0.
- Macro undefined: no `borrow_out` port. The final borrow is computed internally but not exported; all other behaviour is identical.

## Test plan
- WIDTH=4, a=9, b=3, start for 1 cycle:
  - `busy` high 4 cycles, then `done` pulse with `out_diff`=6.
  - `borrow_out`=0 (macro on).
- WIDTH=4, a=3, b=9:
  - `out_diff`=10 (4'hA), `borrow_out`=1.
- WIDTH=4, a=15, b=15, then a=0, b=0:
  - `out_diff`=0 both times, `borrow_out`=0.
  - Each `done` is 5 cycles after its `start`.
- WIDTH=4, a=12, b=5, pulse `start` again 2 cycles later with a=1, b=1:
  - The second start is ignored; a single `done` with `out_diff`=7.
  - `out_diff` stays 7 until the next accepted start completes.
- WIDTH=4, prior result `out_diff`=6, start a=8, b=1, assert `reset` on the 2nd SHIFT cycle:
  - Next edge: `busy`=0, `out_diff`=0, no `done` pulse.
  - A subsequent a=8, b=1 run yields 7.
- WIDTH=8, a=200, b=55:
  - `busy` 8 cycles, `done` at start+9, `out_diff`=145, `borrow_out`=0.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial subtractor with its own control FSM: out_diff = data_a - data_b
// (mod 2^WIDTH). Operands load in parallel on start, are processed LSB-first
// through a one-bit full subtractor with a registered borrow, and the
// difference is published in parallel together with a one-cycle done pulse.
// Optional feature macro: SERIAL_SUB_BORROW_OUT_EN exports the final borrow
// on borrow_out.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out_diff
`ifdef SERIAL_SUB_BORROW_OUT_EN
   ,
   output logic             borrow_out
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] out_diff_q, out_diff_d;
`ifdef SERIAL_SUB_BORROW_OUT_EN
   logic             borrow_out_q, borrow_out_d;
`endif

   logic a0, b0, dbit, br_next;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      diff_d     = diff_q;
      borrow_d   = borrow_q;
      cnt_d      = cnt_q;
      out_diff_d = out_diff_q;
`ifdef SERIAL_SUB_BORROW_OUT_EN
      borrow_out_d = borrow_out_q;
`endif
      // busy is registered, so it trails the SHIFT state by one edge
      busy_d  = (state_q == ST_SHIFT);
      done_d  = 1'b0;

      a0      = a_q[0];
      b0      = b_q[0];
      dbit    = a0 ^ b0 ^ borrow_q;
      br_next = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d      = data_a;
               b_d      = data_b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            a_d      = {1'b0, a_q[WIDTH-1:1]};
            b_d      = {1'b0, b_q[WIDTH-1:1]};
            diff_d   = {dbit, diff_q[WIDTH-1:1]};
            borrow_d = br_next;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_diff_d = diff_q;
`ifdef SERIAL_SUB_BORROW_OUT_EN
            borrow_out_d = borrow_q;
`endif
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         diff_q     <= '0;
         borrow_q   <= 1'b0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         out_diff_q <= '0;
`ifdef SERIAL_SUB_BORROW_OUT_EN
         borrow_out_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         diff_q     <= diff_d;
         borrow_q   <= borrow_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         out_diff_q <= out_diff_d;
`ifdef SERIAL_SUB_BORROW_OUT_EN
         borrow_out_q <= borrow_out_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign out_diff = out_diff_q;
`ifdef SERIAL_SUB_BORROW_OUT_EN
   assign borrow_out = borrow_out_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Testbench for serial_subtractor_ctrl: WIDTH=4 and WIDTH=8 instances,
// scoreboard of expected results popped when done pulses.
// Borrow checks are active when SERIAL_SUB_BORROW_OUT_EN is defined.
module tb_serial_subtractor_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start4, start8;
   logic [3:0] a4, b4;
   logic [7:0] a8, b8;
   logic       busy4, done4, busy8, done8;
   logic [3:0] out_diff4;
   logic [7:0] out_diff8;
   logic       bo4, bo8;

   typedef struct {
      logic [7:0]  d;
      logic        br;
      int unsigned at;
   } exp_t;

   exp_t        q4[$];
   exp_t        q8[$];
   logic [7:0]  hold4, hold8;
   int unsigned cyc;
   int unsigned n_vec, n_err;

   always #5 clk = ~clk;

   serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .data_a(a4), .data_b(b4),
      .busy(busy4), .done(done4), .out_diff(out_diff4)
`ifdef SERIAL_SUB_BORROW_OUT_EN
      , .borrow_out(bo4)
`endif
   );

   serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .data_a(a8), .data_b(b8),
      .busy(busy8), .done(done8), .out_diff(out_diff8)
`ifdef SERIAL_SUB_BORROW_OUT_EN
      , .borrow_out(bo8)
`endif
   );

`ifndef SERIAL_SUB_BORROW_OUT_EN
   assign bo4 = 1'b0;
   assign bo8 = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard side: compare against expected results when done pulses.
   task automatic monitor();
      exp_t e;
      if (reset) begin
         q4.delete();
         q8.delete();
         hold4 = '0;
         hold8 = '0;
      end
      if (done4) begin
         if (q4.size() == 0) check("done4_spurious", 32'(done4), 32'd0);
         else begin
            e = q4.pop_front();
            hold4 = e.d;
            check("diff4", 32'(out_diff4), 32'(e.d[3:0]));
            check("lat4", cyc, e.at);
`ifdef SERIAL_SUB_BORROW_OUT_EN
            check("borrow4", 32'(bo4), 32'(e.br));
`endif
         end
      end
      if (done8) begin
         if (q8.size() == 0) check("done8_spurious", 32'(done8), 32'd0);
         else begin
            e = q8.pop_front();
            hold8 = e.d;
            check("diff8", 32'(out_diff8), 32'(e.d));
            check("lat8", cyc, e.at);
`ifdef SERIAL_SUB_BORROW_OUT_EN
            check("borrow8", 32'(bo8), 32'(e.br));
`endif
         end
      end
      check("hold4", 32'(out_diff4), 32'(hold4[3:0]));
      check("hold8", 32'(out_diff8), 32'(hold8));
   endtask

   // One clock: rising edge, then observe on the falling edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      monitor();
   endtask

   task automatic push4(input logic [3:0] a, input logic [3:0] b, input int unsigned k);
      exp_t e;
      logic [3:0] d;
      d    = a - b;
      e.d  = {4'h0, d};
      e.br = (a < b);
      e.at = k + 5;
      q4.push_back(e);
   endtask

   task automatic push8(input logic [7:0] a, input logic [7:0] b, input int unsigned k);
      exp_t e;
      e.d  = a - b;
      e.br = (a < b);
      e.at = k + 9;
      q8.push_back(e);
   endtask

   task automatic go4(input logic [3:0] a, input logic [3:0] b, input bit accept);
      a4 = a; b4 = b; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      a4 = ~a; b4 = ~b;
      if (accept) push4(a, b, cyc);
   endtask

   task automatic go8(input logic [7:0] a, input logic [7:0] b);
      a8 = a; b8 = b; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = ~a; b8 = ~b;
      push8(a, b, cyc);
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      while ((q4.size() != 0 || q8.size() != 0) && n < 40) begin
         tick();
         n++;
      end
      if (q4.size() != 0 || q8.size() != 0) begin
         check("timeout", 32'(q4.size() + q8.size()), 32'd0);
         q4.delete();
         q8.delete();
      end
      tick();
   endtask

   initial begin
      cyc = 0; n_vec = 0; n_err = 0;
      hold4 = '0; hold8 = '0;
      reset = 1'b1; start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      @(negedge clk);
      tick();
      tick();
      check("rst_busy4", 32'(busy4), 32'd0);
      check("rst_done4", 32'(done4), 32'd0);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_borrow4", 32'(bo4), 32'd0);
      reset = 1'b0;
      tick();

      // 9 - 3 with busy profile
      go4(4'd9, 4'd3, 1'b1);
      check("busy4_k", 32'(busy4), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("busy4_shift", 32'(busy4), 32'd1);
         check("done4_early", 32'(done4), 32'd0);
      end
      tick();
      check("busy4_done", 32'(busy4), 32'd0);
      check("done4_pulse", 32'(done4), 32'd1);
      tick();
      check("done4_one", 32'(done4), 32'd0);
      wait_idle();

      // borrow and all-equal / all-zero cases
      go4(4'd3, 4'd9, 1'b1);
      wait_idle();
      go4(4'd15, 4'd15, 1'b1);
      wait_idle();
      go4(4'd0, 4'd0, 1'b1);
      wait_idle();

      // a start during SHIFT is ignored
      go4(4'd12, 4'd5, 1'b1);
      tick();
      go4(4'd1, 4'd1, 1'b0);
      wait_idle();
      repeat (6) tick();
      check("diff4_held", 32'(out_diff4), 32'd7);

      // reset during the second SHIFT cycle discards the operation
      go4(4'd9, 4'd3, 1'b1);
      wait_idle();
      go4(4'd8, 4'd1, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy4", 32'(busy4), 32'd0);
      check("midrst_diff4", 32'(out_diff4), 32'd0);
      check("midrst_done4", 32'(done4), 32'd0);
      repeat (8) tick();
      go4(4'd8, 4'd1, 1'b1);
      wait_idle();

      // WIDTH=8: 200 - 55 with busy profile
      go8(8'd200, 8'd55);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("busy8_shift", 32'(busy8), 32'd1);
      end
      tick();
      check("busy8_done", 32'(busy8), 32'd0);
      check("done8_pulse", 32'(done8), 32'd1);
      wait_idle();

      // start held high: restarts every WIDTH+2 cycles
      a4 = 4'd6; b4 = 4'd2; start4 = 1'b1;
      tick();
      push4(4'd6, 4'd2, cyc);
      repeat (6) tick();
      push4(4'd6, 4'd2, cyc);
      start4 = 1'b0;
      wait_idle();

      // random vectors on both widths concurrently
      for (int i = 0; i < 10; i++) begin
         logic [3:0] ra, rb;
         logic [7:0] sa, sb;
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         sa = 8'($urandom_range(0, 255));
         sb = 8'($urandom_range(0, 255));
         a4 = ra; b4 = rb; start4 = 1'b1;
         a8 = sa; b8 = sb; start8 = 1'b1;
         tick();
         push4(ra, rb, cyc);
         push8(sa, sb, cyc);
         start4 = 1'b0; start8 = 1'b0;
         a4 = $urandom_range(0, 15); a8 = $urandom_range(0, 255);
         wait_idle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
